// File: rtl/ysyx_24080014_pkg.sv
// Shared types and constants for the ysyx_24080014 instruction fetch unit.
package ysyx_24080014_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h8000_0000;

    // Fetch sequencer states.
    typedef enum logic [2:0] {
        BOOT     = 3'd0,
        REQ      = 3'd1,
        WAIT     = 3'd2,
        HOLD     = 3'd3,
        WAIT_NPC = 3'd4
    } ifu_state_t;

    // Instruction fetches must be word aligned.
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_24080014_pc_reg.sv
// Program counter register: resets to RESET_PC, loads load_pc when load_en is high.
module ysyx_24080014_pc_reg
    import ysyx_24080014_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_en,
    input  logic [XLEN-1:0] load_pc,
    output logic [XLEN-1:0] pc
);

    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_q;

    // Next-PC selection: hold unless a load is requested.
    always_comb begin
        // NOTE: assign a default first so every path drives pc_d and no latch is inferred.
        pc_d = pc_q;
        if (load_en) begin
            pc_d = load_pc;
        end
    end

    // PC storage with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/ysyx_24080014_ifu.sv
// Instruction fetch unit: issues one word read per instruction, holds the
// result for decode, then waits for write-back to provide the next PC.
module ysyx_24080014_ifu
    import ysyx_24080014_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    // Instruction memory request / response
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [XLEN-1:0]  mem_req_addr,
    input  logic             mem_resp_valid,
    input  logic [XLEN-1:0]  mem_resp_data,
    // Decode-side handshake
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_inst,
    output logic             out_misalign,
    // Next PC from write-back
    input  logic             npc_valid,
    input  logic [XLEN-1:0]  npc,
    // Completed decode handshakes
    output logic [CNT_W-1:0] fetch_cnt
);

    ifu_state_t       state_q,    state_d;
    logic [XLEN-1:0]  inst_q,     inst_d;
    logic [XLEN-1:0]  out_pc_q,   out_pc_d;
    logic             misalign_q, misalign_d;
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;

    logic [XLEN-1:0]  pc;
    logic             pc_load;
    logic             pc_bad;

    ysyx_24080014_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .rst     (rst),
        .load_en (pc_load),
        .load_pc (npc),
        .pc      (pc)
    );

    assign pc_bad = is_misaligned(pc);

    // Sequencer next-state and datapath update decisions.
    always_comb begin
        state_d     = state_q;
        inst_d      = inst_q;
        out_pc_d    = out_pc_q;
        misalign_d  = misalign_q;
        fetch_cnt_d = fetch_cnt_q;
        pc_load     = 1'b0;

        unique case (state_q)
            BOOT: begin
                misalign_d = 1'b0;
                state_d    = REQ;
            end
            REQ: begin
                // pc is stable from here until the next WAIT_NPC, so tag it now.
                out_pc_d = pc;
                if (pc_bad) begin
                    inst_d     = '0;
                    misalign_d = 1'b1;
                    state_d    = HOLD;
                end else if (mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    inst_d  = mem_resp_data;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
                    state_d     = WAIT_NPC;
                end
            end
            WAIT_NPC: begin
                if (npc_valid) begin
                    pc_load    = 1'b1;
                    misalign_d = 1'b0;
                    state_d    = REQ;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State, captured instruction, tag and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BOOT;
            inst_q      <= '0;
            out_pc_q    <= RESET_PC;
            misalign_q  <= 1'b0;
            fetch_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            inst_q      <= inst_d;
            out_pc_q    <= out_pc_d;
            misalign_q  <= misalign_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    // Outputs decoded from registered state only, so they are stable within a cycle.
    assign mem_req_valid = (state_q == REQ) && !pc_bad;
    assign mem_req_addr  = pc;
    assign out_valid     = (state_q == HOLD);
    assign out_pc        = out_pc_q;
    assign out_inst      = inst_q;
    assign out_misalign  = misalign_q;
    assign fetch_cnt     = fetch_cnt_q;

endmodule

// File: tb/tb_ysyx_24080014_ifu.sv
// Directed bench for ysyx_24080014_ifu: cycle table plus hand-written fetch loop.
module tb_ysyx_24080014_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        out_ready;
    logic        npc_valid;
    logic [31:0] npc;

    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_misalign;
    logic [31:0] fetch_cnt;

    logic        s_req_valid, s_out_valid, s_misalign;
    logic [31:0] s_req_addr, s_out_pc, s_out_inst;
    logic [1:0]  s_fetch_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ysyx_24080014_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_misalign   (out_misalign),
        .npc_valid      (npc_valid),
        .npc            (npc),
        .fetch_cnt      (fetch_cnt)
    );

    // Narrow-counter instance sharing the same stimulus, used to observe wrap.
    ysyx_24080014_ifu #(.CNT_W(2)) dut_small (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (s_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (s_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .out_valid      (s_out_valid),
        .out_ready      (out_ready),
        .out_pc         (s_out_pc),
        .out_inst       (s_out_inst),
        .out_misalign   (s_misalign),
        .npc_valid      (npc_valid),
        .npc            (npc),
        .fetch_cnt      (s_fetch_cnt)
    );

    typedef struct {
        logic        rst;
        logic        req_ready;
        logic        resp_valid;
        logic [31:0] resp_data;
        logic        o_ready;
        logic        n_valid;
        logic [31:0] n_pc;
        logic        e_req_valid;
        logic [31:0] e_req_addr;
        logic        e_out_valid;
        logic [31:0] e_out_pc;
        logic [31:0] e_out_inst;
        logic        e_misalign;
        logic [31:0] e_cnt;
    } vec_t;

    localparam int NV = 30;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic r, input logic rdy, input logic rv, input logic [31:0] rd,
                                input logic ordy, input logic nv, input logic [31:0] np,
                                input logic erv, input logic [31:0] era, input logic eov,
                                input logic [31:0] epc, input logic [31:0] einst,
                                input logic emis, input logic [31:0] ecnt);
        vec_t v;
        v.rst = r; v.req_ready = rdy; v.resp_valid = rv; v.resp_data = rd;
        v.o_ready = ordy; v.n_valid = nv; v.n_pc = np;
        v.e_req_valid = erv; v.e_req_addr = era; v.e_out_valid = eov;
        v.e_out_pc = epc; v.e_out_inst = einst; v.e_misalign = emis; v.e_cnt = ecnt;
        return v;
    endfunction

    // One complete fetch from REQ back to REQ, with a response two cycles after acceptance.
    task automatic do_fetch(input logic [31:0] exp_pc, input logic [31:0] data, input logic [31:0] next_pc);
        int n;
        mem_req_ready = 1'b1;
        n = 0;
        while (!mem_req_valid && n < 10) begin
            step();
            n++;
        end
        check("loop_req_seen", {31'b0, mem_req_valid}, 32'd1);
        check("loop_req_addr", mem_req_addr, exp_pc);
        step();
        mem_req_ready = 1'b0;
        step();
        mem_resp_valid = 1'b1;
        mem_resp_data  = data;
        step();
        mem_resp_valid = 1'b0;
        check("loop_out_valid", {31'b0, out_valid}, 32'd1);
        check("loop_out_inst", out_inst, data);
        check("loop_out_pc", out_pc, exp_pc);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        npc_valid = 1'b1;
        npc       = next_pc;
        step();
        npc_valid = 1'b0;
    endtask

    localparam logic [31:0] P0 = 32'h8000_0000;
    localparam logic [31:0] P4 = 32'h8000_0004;
    localparam logic [31:0] P6 = 32'h8000_0006;
    localparam logic [31:0] P8 = 32'h8000_0008;
    localparam logic [31:0] I1 = 32'h0000_0413;
    localparam logic [31:0] I2 = 32'h0000_0093;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;

    initial begin
        //             rst rdy rv data  ordy nv npc    | erv addr ov  opc  inst mis cnt
        vecs[0]  = mk(1, 0, 0, 0,    0, 0, 0,     0, P0, 0, P0, 0,  0, 0);
        vecs[1]  = mk(1, 0, 0, 0,    0, 0, 0,     0, P0, 0, P0, 0,  0, 0);
        vecs[2]  = mk(1, 0, 0, 0,    0, 0, 0,     0, P0, 0, P0, 0,  0, 0);
        vecs[3]  = mk(0, 0, 0, 0,    0, 0, 0,     0, P0, 0, P0, 0,  0, 0);
        vecs[4]  = mk(0, 0, 0, 0,    0, 0, 0,     1, P0, 0, P0, 0,  0, 0);
        vecs[5]  = mk(0, 0, 1, BAD,  0, 0, 0,     1, P0, 0, P0, 0,  0, 0);
        vecs[6]  = mk(0, 0, 0, 0,    0, 0, 0,     1, P0, 0, P0, 0,  0, 0);
        vecs[7]  = mk(0, 0, 0, 0,    0, 0, 0,     1, P0, 0, P0, 0,  0, 0);
        vecs[8]  = mk(0, 0, 0, 0,    0, 0, 0,     1, P0, 0, P0, 0,  0, 0);
        vecs[9]  = mk(0, 1, 0, 0,    0, 0, 0,     1, P0, 0, P0, 0,  0, 0);
        vecs[10] = mk(0, 0, 0, 0,    0, 0, 0,     0, P0, 0, P0, 0,  0, 0);
        vecs[11] = mk(0, 0, 1, I1,   0, 0, 0,     0, P0, 0, P0, 0,  0, 0);
        vecs[12] = mk(0, 0, 0, 0,    0, 0, 0,     0, P0, 1, P0, I1, 0, 0);
        vecs[13] = mk(0, 0, 0, 0,    0, 1, 32'h1234_5678, 0, P0, 1, P0, I1, 0, 0);
        vecs[14] = mk(0, 0, 1, BAD,  0, 0, 0,     0, P0, 1, P0, I1, 0, 0);
        vecs[15] = mk(0, 0, 0, 0,    0, 0, 0,     0, P0, 1, P0, I1, 0, 0);
        vecs[16] = mk(0, 0, 0, 0,    1, 0, 0,     0, P0, 1, P0, I1, 0, 0);
        vecs[17] = mk(0, 0, 0, 0,    0, 0, 0,     0, P0, 0, P0, I1, 0, 1);
        vecs[18] = mk(0, 0, 0, 0,    0, 1, P4,    0, P0, 0, P0, I1, 0, 1);
        vecs[19] = mk(0, 1, 0, 0,    0, 0, 0,     1, P4, 0, P0, I1, 0, 1);
        vecs[20] = mk(0, 0, 1, I2,   0, 0, 0,     0, P4, 0, P4, I1, 0, 1);
        vecs[21] = mk(0, 0, 0, 0,    1, 0, 0,     0, P4, 1, P4, I2, 0, 1);
        vecs[22] = mk(0, 0, 0, 0,    0, 1, P6,    0, P4, 0, P4, I2, 0, 2);
        vecs[23] = mk(0, 1, 0, 0,    0, 0, 0,     0, P6, 0, P4, I2, 0, 2);
        vecs[24] = mk(0, 0, 0, 0,    1, 0, 0,     0, P6, 1, P6, 0,  1, 2);
        vecs[25] = mk(0, 0, 0, 0,    0, 1, P8,    0, P6, 0, P6, 0,  1, 3);
        vecs[26] = mk(0, 1, 0, 0,    0, 0, 0,     1, P8, 0, P6, 0,  0, 3);
        vecs[27] = mk(1, 0, 0, 0,    0, 0, 0,     0, P8, 0, P8, 0,  0, 3);
        vecs[28] = mk(0, 0, 1, 32'hCAFE_0001, 0, 0, 0, 0, P0, 0, P0, 0, 0, 0);
        vecs[29] = mk(0, 0, 1, 32'hCAFE_0002, 0, 0, 0, 1, P0, 0, P0, 0, 0, 0);

        rst = 1'b1; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        out_ready = 1'b0; npc_valid = 1'b0; npc = '0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            rst            = vecs[i].rst;
            mem_req_ready  = vecs[i].req_ready;
            mem_resp_valid = vecs[i].resp_valid;
            mem_resp_data  = vecs[i].resp_data;
            out_ready      = vecs[i].o_ready;
            npc_valid      = vecs[i].n_valid;
            npc            = vecs[i].n_pc;
            #1;
            check($sformatf("v%0d_req_valid", i), {31'b0, mem_req_valid}, {31'b0, vecs[i].e_req_valid});
            check($sformatf("v%0d_req_addr", i), mem_req_addr, vecs[i].e_req_addr);
            check($sformatf("v%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_out_valid});
            check($sformatf("v%0d_out_pc", i), out_pc, vecs[i].e_out_pc);
            check($sformatf("v%0d_out_inst", i), out_inst, vecs[i].e_out_inst);
            check($sformatf("v%0d_misalign", i), {31'b0, out_misalign}, {31'b0, vecs[i].e_misalign});
            check($sformatf("v%0d_fetch_cnt", i), fetch_cnt, vecs[i].e_cnt);
            step();
        end

        // Still in REQ at RESET_PC; run five back-to-back fetches.
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b0;
        do_fetch(P0, 32'h0010_0093, 32'h8000_0010);
        do_fetch(32'h8000_0010, 32'h0020_0113, 32'h8000_0014);
        do_fetch(32'h8000_0014, 32'h0030_0193, 32'h8000_0100);
        do_fetch(32'h8000_0100, 32'h0040_0213, 32'h8000_0104);
        do_fetch(32'h8000_0104, 32'h0050_0293, 32'h8000_0108);
        check("loop_fetch_cnt", fetch_cnt, 32'd5);
        check("wrap_fetch_cnt", {30'b0, s_fetch_cnt}, 32'd1);
        check("loop_next_addr", mem_req_addr, 32'h8000_0108);
        check("loop_next_req", {31'b0, mem_req_valid}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
